// File: rtl/display_decoder.sv
// Multiplexed common-anode 7-segment capture: sync, debounce, decode per digit.
// DISPLAY_DECODER_DP_EN: capture decimal point per digit into dp_out.
module display_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS-1:0]     anodes,
  input  logic [6:0]            cathodes,
  input  logic                  dp,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     dp_out,
  output logic                  seg_error,
  output logic                  frame_done
);

`ifdef DISPLAY_DECODER_DP_EN
  localparam int W = DIGITS + 8;
`else
  localparam int W = DIGITS + 7;
`endif
  localparam logic [7:0] SAT = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_e;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [W-1:0] raw, s1_q, s2_q, last_q;
  logic [DIGITS-1:0] sel;
  logic [6:0] cat_s;
  logic none, multi, change, commit;
  logic [4:0] dec;
  logic is_blank;

  logic [4*DIGITS-1:0] dig_q, dig_d;
  logic [DIGITS-1:0] val_q, val_d, blk_q, blk_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic err_q, err_d, done_q, done_d;

`ifdef DISPLAY_DECODER_DP_EN
  logic [DIGITS-1:0] dpo_q, dpo_d;
  assign raw = {dp, anodes, cathodes};
`else
  logic unused_dp;
  assign unused_dp = dp;
  assign raw = {anodes, cathodes};
`endif

  // {legal, nibble}; blank and illegal both return legal = 0
  function automatic logic [4:0] decode(input logic [6:0] c);
    case (c)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b0000011: decode = 5'h1B;
      7'b1000110: decode = 5'h1C;
      7'b0100001: decode = 5'h1D;
      7'b0000110: decode = 5'h1E;
      7'b0001110: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  assign sel      = ~s2_q[DIGITS+6:7];
  assign cat_s    = s2_q[6:0];
  assign none     = (sel == '0);
  assign multi    = !none && ((sel & (sel - DIGITS'(1))) != '0);
  assign change   = (s2_q != last_q);
  assign dec      = decode(cat_s);
  assign is_blank = (cat_s == 7'h7F);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (none || multi) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (change || state_q == IDLE) begin
      state_d = TRACK;
      cnt_d   = 8'd1;
    end else if (state_q == TRACK) begin
      if (cnt_q == SAT) begin
        commit  = 1'b1;
        state_d = HOLD;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    dig_d  = dig_q;
    val_d  = val_q;
    blk_d  = blk_q;
    mask_d = mask_q;
    err_d  = err_q | multi;
    done_d = 1'b0;
`ifdef DISPLAY_DECODER_DP_EN
    dpo_d  = dpo_q;
`endif
    if (commit && !clear) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel[i]) begin
          mask_d[i] = 1'b1;
          val_d[i]  = dec[4];
          blk_d[i]  = is_blank;
          if (dec[4]) dig_d[4*i +: 4] = dec[3:0];
          if (!dec[4] && !is_blank) err_d = 1'b1;
`ifdef DISPLAY_DECODER_DP_EN
          dpo_d[i] = ~s2_q[W-1];
`endif
        end
      end
      if (&mask_d) begin
        done_d = 1'b1;
        mask_d = '0;
      end
    end
    if (clear) begin
      val_d  = '0;
      blk_d  = '0;
      mask_d = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= '1;
      s2_q    <= '1;
      last_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      dig_q   <= '0;
      val_q   <= '0;
      blk_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      last_q  <= s2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      val_q   <= val_d;
      blk_q   <= blk_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

`ifdef DISPLAY_DECODER_DP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dpo_q <= '0;
    else        dpo_q <= dpo_d;
  end
  assign dp_out = dpo_q;
`else
  assign dp_out = '0;
`endif

  assign digits      = dig_q;
  assign digit_valid = val_q;
  assign blank       = blk_q;
  assign seg_error   = err_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_display_decoder.sv
// Bench for display_decoder: table of dwells plus latency/clear/mask/reset/dp sequences.
module tb_display_decoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] anodes = 4'b1111;
  logic [6:0] cathodes = 7'h7F;
  logic dp = 1'b1;
  logic clear = 1'b0;
  logic [15:0] digits;
  logic [3:0] digit_valid, blank, dp_out;
  logic seg_error, frame_done;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  display_decoder #(.DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .anodes(anodes), .cathodes(cathodes),
    .dp(dp), .clear(clear), .digits(digits), .digit_valid(digit_valid),
    .blank(blank), .dp_out(dp_out), .seg_error(seg_error),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  typedef struct {
    logic        clr;
    logic [3:0]  an;
    logic [6:0]  cat;
    int          n;
    logic [15:0] dig;
    logic [3:0]  val;
    logic [3:0]  blk;
    logic        err;
    int          fd;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    anodes = 4'b1111;
    repeat (n) @(negedge clk);
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] cat,
                       input int n);
    anodes   = an;
    cathodes = cat;
    repeat (n) @(negedge clk);
    idle(4);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int fd0;
    logic [3:0] dp_exp;
    tbl[0] = '{1'b0, 4'b1110, 7'b0110000, 20, 16'h0003, 4'b0001, 4'b0000, 1'b0, 0};
    tbl[1] = '{1'b0, 4'b1101, 7'b0001000, 20, 16'h00A3, 4'b0011, 4'b0000, 1'b0, 0};
    tbl[2] = '{1'b0, 4'b1011, 7'b0000011, 20, 16'h0BA3, 4'b0111, 4'b0000, 1'b0, 0};
    tbl[3] = '{1'b0, 4'b0111, 7'b0001110, 20, 16'hFBA3, 4'b1111, 4'b0000, 1'b0, 1};
    tbl[4] = '{1'b0, 4'b1101, 7'b0100100,  9, 16'hFB23, 4'b1111, 4'b0000, 1'b0, 1};
    tbl[5] = '{1'b0, 4'b1011, 7'b0100100,  8, 16'hFB23, 4'b1111, 4'b0000, 1'b0, 1};
    tbl[6] = '{1'b0, 4'b1110, 7'b1111111, 20, 16'hFB23, 4'b1110, 4'b0001, 1'b0, 1};
    tbl[7] = '{1'b0, 4'b1110, 7'b1010101, 20, 16'hFB23, 4'b1110, 4'b0000, 1'b1, 1};
    tbl[8] = '{1'b0, 4'b0111, 7'b0000000, 20, 16'h8B23, 4'b1110, 4'b0000, 1'b1, 1};
    tbl[9] = '{1'b1, 4'b0011, 7'b1000000, 20, 16'h8B23, 4'b0000, 4'b0000, 1'b1, 1};

    repeat (3) @(negedge clk);
    chk("rst_digits", digits, 16'h0);
    chk("rst_flags", {digit_valid, blank, dp_out, seg_error, frame_done}, 0);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_flags", {digits, digit_valid, blank, dp_out, seg_error}, 0);
    chk("idle_fd", fd_cnt, 0);

    for (int k = 0; k < 10; k++) begin
      if (tbl[k].clr) pulse_clear();
      dwell(tbl[k].an, tbl[k].cat, tbl[k].n);
      chk($sformatf("v%0d_digits", k), digits, tbl[k].dig);
      chk($sformatf("v%0d_valid", k), digit_valid, tbl[k].val);
      chk($sformatf("v%0d_blank", k), blank, tbl[k].blk);
      chk($sformatf("v%0d_err", k), seg_error, tbl[k].err);
      chk($sformatf("v%0d_fd", k), fd_cnt, tbl[k].fd);
      chk($sformatf("v%0d_dp", k), dp_out, 4'b0000);
    end

    pulse_clear();
    chk("clr_err", seg_error, 1'b0);
    anodes   = 4'b1110;
    cathodes = 7'b0010010;
    repeat (10) @(negedge clk);
    chk("lat_early", digits, 16'h8B23);
    @(negedge clk);
    chk("lat_digits", digits, 16'h8B25);
    chk("lat_valid", digit_valid, 4'b0001);
    idle(4);

    anodes   = 4'b1101;
    cathodes = 7'b1111001;
    repeat (10) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clrwin_digits", digits, 16'h8B25);
    chk("clrwin_flags", {digit_valid, blank, seg_error}, 0);
    repeat (5) @(negedge clk);
    chk("hold_nocommit", digit_valid, 4'b0000);
    idle(4);

    fd0 = fd_cnt;
    dwell(4'b1110, 7'b1111001, 20);
    dwell(4'b1101, 7'b0100100, 20);
    dwell(4'b1011, 7'b0110000, 20);
    chk("mask_partial", fd_cnt, fd0);
    pulse_clear();
    dwell(4'b0111, 7'b0011001, 20);
    chk("mask_cleared", fd_cnt, fd0);
    dwell(4'b1110, 7'b1111001, 20);
    dwell(4'b1101, 7'b0100100, 20);
    dwell(4'b1110, 7'b0010000, 20);
    chk("mask_recommit", fd_cnt, fd0);
    dwell(4'b1011, 7'b0110000, 20);
    chk("mask_frame", fd_cnt, fd0 + 1);
    chk("mask_digits", digits, 16'h4329);
    chk("fd_low", frame_done, 1'b0);

    anodes   = 4'b1011;
    cathodes = 7'b0000110;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_digits", digits, 16'h0);
    chk("midrst_valid", digit_valid, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    repeat (14) @(negedge clk);
    chk("postrst_digits", digits, 16'h0E00);
    chk("postrst_valid", digit_valid, 4'b0100);
    idle(4);

    dp = 1'b0;
    dwell(4'b1011, 7'b0000000, 20);
    dp = 1'b1;
`ifdef DISPLAY_DECODER_DP_EN
    dp_exp = 4'b0100;
`else
    dp_exp = 4'b0000;
`endif
    chk("dp_out", dp_out, dp_exp);
    chk("dp_digit", digits, 16'h0800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_decoder.md
# display_decoder

Front-panel segment capture block: samples a multiplexed, common-anode 7-segment bus (active-low anodes, active-low cathodes, active-low dp), debounces each digit's dwell, and decodes the segment pattern back into a hex nibble per digit. It is the read side of the display encoder path. Uses include board-level loopback self-test and hardware-in-loop verification of the display drivers. Output is a register file of decoded digits, plus per-digit status and a frame-complete pulse.

## Interface
- Parameters:
- `DIGITS`, default 4: number of multiplexed digits / anode lines (1–8).
- `STABLE_CYCLES`, default 8: consecutive identical synchronized samples required before a digit is committed (2–255).
- Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset; deassertion is synchronised by the integrating top level.
- `anodes`  in  DIGITS  digit enables, active-low; bit i low selects digit i.
- `cathodes`  in  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  in  1  decimal point, active-low.
- `clear`  in  1  synchronous; clears `digit_valid`, `blank`, `seg_error`, and the frame-seen mask.
- `digits`  out  4*DIGITS  decoded nibbles; digit i at [4i+3:4i].
- `digit_valid`  out  DIGITS  digit i holds a legal decoded nibble.
- `blank`  out  DIGITS  digit i last committed as all-segments-off (1111111).
- `dp_out`  out  DIGITS  captured decimal point per digit, active-high.
- `seg_error`  out  1  sticky: illegal pattern committed, or more than one anode low.
- `frame_done`  out  1  one-cycle pulse once every digit has committed since the last pulse or clear.

## Operation
- Inputs pass through a 2-flop synchroniser (`anodes`, `cathodes`, `dp` as one vector).
- Decode table, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. 1111111 is blank. Any other pattern is illegal.
- FSM states:
- IDLE: no anode low. Counter = 0.
- TRACK: exactly one anode low. Count consecutive identical synchronized samples, saturating at STABLE_CYCLES.
- HOLD: digit already committed for this dwell. No further commits until the sampled vector changes.
- Transitions:
- Sample changes → TRACK with count = 1.
- Count reaches STABLE_CYCLES → commit, then HOLD.
- No anode low → IDLE.
- More than one anode low → IDLE, and `seg_error` is set.
- Commit of digit i writes, by decoded pattern:
- Legal: nibble → `digits[i]`, `digit_valid[i]`=1, `blank[i]`=0.
- Blank: `digits[i]` unchanged, `digit_valid[i]`=0, `blank[i]`=1.
- Illegal: `digits[i]` unchanged, `digit_valid[i]`=0, `blank[i]`=0, `seg_error` set.
- Every commit sets seen-mask bit i. When the mask becomes all-ones, `frame_done` pulses and the mask clears.
- Simultaneous events:
- `clear` in the same cycle as a commit: clear wins; the commit is discarded and the mask is cleared.
- A re-commit of an already-seen digit before the frame completes leaves the mask unchanged.

## Timing
- Reset values: `digits`=0, `digit_valid`=0, `blank`=0, `dp_out`=0, `seg_error`=0, `frame_done`=0; FSM in IDLE, counter 0, mask 0.
- Latency: inputs stable before edge 0 → outputs update at edge STABLE_CYCLES+2 (2 synchroniser edges plus STABLE_CYCLES counting edges).
- A dwell shorter than STABLE_CYCLES+1 cycles never commits.
- `frame_done` is asserted on the same edge as the completing commit's outputs, for exactly one cycle.
- Reset assertion mid-dwell returns all state to reset values immediately. After reset release, capture restarts from IDLE.

## Configuration
- `DISPLAY_DECODER_DP_EN` defined: `dp_out[i]` = ~dp on each commit of digit i, including blank and illegal commits. `dp` joins the stability compare.
- `DISPLAY_DECODER_DP_EN` undefined: `dp` is ignored (not compared, not stored) and `dp_out` is tied to 0.

## Test plan
- Reset held, then released with `anodes`=1111: all outputs 0 and `frame_done` never pulses.
- DIGITS=4, STABLE_CYCLES=8; scan digits 0..3 showing 0x3,0xA,0xb,0xF for 20 cycles each → `digits`=16'hFBA3, `digit_valid`=1111, one `frame_done` pulse, `seg_error`=0.
- Digit 1 driven 0100100 for 9 cycles, then 0100100 for only 8 cycles on digit 2 → digit 1 reads 2, digit 2 not committed.
- Digit 0 driven 1111111 → `blank[0]`=1, `digit_valid[0]`=0. Digit 0 driven 1010101 → `seg_error`=1, and it stays 1 until `clear`.
- `anodes`=1100 held 20 cycles → `seg_error`=1, no commit. Then `clear` asserted on the same cycle as a pending commit → all flags 0, mask empty.
- With the macro defined, digit 2 shows 8 with dp=0 → `dp_out`=0100. With the macro undefined, the same stimulus → `dp_out`=0000.
